xprop_logic_pipe: RTL

//  LANES-wide, DEPTH-stage registered pipeline that computes a 2-operand logic op on explicitly
//  4-state-encoded signals (value + known bit per lane). It propagates X exactly like the simulator core.

---
 rtl/xprop_pkg.sv | 27 ++
 rtl/xprop_cell.sv | 46 ++++
 rtl/xprop_logic_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/xprop_pkg.sv
// Shared types for the 4-state X-propagation pipeline: op encoding, lane
// struct and the canonical-X helper.
package xprop_pkg;

   typedef enum logic [1:0] {
      OP_NOT = 2'b00,
      OP_AND = 2'b01,
      OP_OR  = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   typedef struct packed {
      logic val;
      logic known;
   } lane_t;

   localparam lane_t X_LANE = '{val: 1'b0, known: 1'b0};

   // An unknown lane always carries val=0 so downstream compares are stable.
   function automatic lane_t canon(input lane_t l);
      lane_t r;
      r.known = l.known;
      r.val   = l.val & l.known;
      return r;
   endfunction

endpackage

// File: rtl/xprop_cell.sv
// One combinational lane operator on {val, known} pairs.
// XPROP_PESSIMISTIC_EN: AND/OR become known only when both inputs are known.
module xprop_cell
   import xprop_pkg::*;
(
   input  op_e   op,
   input  lane_t a,
   input  lane_t b,
   output lane_t r
);

   lane_t raw;

   always_comb begin
      raw = X_LANE;
      unique case (op)
         OP_NOT: begin
            raw.known = a.known;
            raw.val   = ~a.val;
         end
         OP_AND: begin
`ifdef XPROP_PESSIMISTIC_EN
            raw.known = a.known & b.known;
`else
            // A known 0 on either side dominates the other operand.
            raw.known = (a.known & b.known) | (a.known & ~a.val) | (b.known & ~b.val);
`endif
            raw.val   = a.val & b.val;
         end
         OP_OR: begin
`ifdef XPROP_PESSIMISTIC_EN
            raw.known = a.known & b.known;
`else
            raw.known = (a.known & b.known) | (a.known & a.val) | (b.known & b.val);
`endif
            raw.val   = a.val | b.val;
         end
         OP_XOR: begin
            raw.known = a.known & b.known;
            raw.val   = a.val ^ b.val;
         end
      endcase
      r = canon(raw);
   end

endmodule

// File: rtl/xprop_logic_pipe.sv
// LANES-wide, DEPTH-stage pipeline of 4-state logic ops with a settle counter.
// Optional macro XPROP_PESSIMISTIC_EN selects gate-level AND/OR pessimism (in xprop_cell).
module xprop_logic_pipe
   import xprop_pkg::*;
#(
   parameter int LANES = 4,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic [1:0]       op,
   input  logic [LANES-1:0] a_val,
   input  logic [LANES-1:0] a_known,
   input  logic [LANES-1:0] b_val,
   input  logic [LANES-1:0] b_known,
   output logic [LANES-1:0] out_val,
   output logic [LANES-1:0] out_known,
   output logic             out_valid,
   output logic             all_known,
   output logic [CNT_W-1:0] settle_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (&c)
         return c;
      return c + CNT_W'(1);
   endfunction

   op_e              op_s;
   logic [LANES-1:0] res_val;
   logic [LANES-1:0] res_known;

   assign op_s = op_e'(op);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      lane_t a_l, b_l, r_l;
      assign a_l = '{val: a_val[l], known: a_known[l]};
      assign b_l = '{val: b_val[l], known: b_known[l]};
      xprop_cell u_cell (
         .op (op_s),
         .a  (a_l),
         .b  (b_l),
         .r  (r_l)
      );
      assign res_val[l]   = r_l.val;
      assign res_known[l] = r_l.known;
   end

   // Stage 0 computes; stages 1..DEPTH-1 copy
   logic [LANES-1:0] val_p   [DEPTH];
   logic [LANES-1:0] known_p [DEPTH];
   logic             vld_p   [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < DEPTH; s++) begin
            val_p[s]   <= '0;
            known_p[s] <= '0;
            vld_p[s]   <= 1'b0;
         end
      end else if (en) begin
         val_p[0]   <= res_val;
         known_p[0] <= res_known;
         vld_p[0]   <= in_valid;
         for (int s = 1; s < DEPTH; s++) begin
            val_p[s]   <= val_p[s-1];
            known_p[s] <= known_p[s-1];
            vld_p[s]   <= vld_p[s-1];
         end
      end
   end

   assign out_val   = val_p[DEPTH-1];
   assign out_known = known_p[DEPTH-1];
   assign out_valid = vld_p[DEPTH-1];

   // Value about to be loaded into the last stage, used for all_known and settling
   logic [LANES-1:0] last_known_d;
   logic             last_vld_d;
   logic             all_known_d;

   if (DEPTH == 1) begin : g_last_d1
      assign last_known_d = res_known;
      assign last_vld_d   = in_valid;
   end else begin : g_last_dn
      assign last_known_d = known_p[DEPTH-2];
      assign last_vld_d   = vld_p[DEPTH-2];
   end

   assign all_known_d = en ? (last_vld_d & (&last_known_d)) : all_known;

   // Output flag and settle counter
   logic settled;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         all_known  <= 1'b0;
         settle_cnt <= '0;
         settled    <= 1'b0;
      end else begin
         all_known <= all_known_d;
         if (!settled) begin
            settle_cnt <= sat_inc(settle_cnt);
            settled    <= all_known_d;
         end
      end
   end

endmodule
